deserializer_n: RTL

DESERIALIZER_N -- requirements
Module: deserializer_n

---
 rtl/deserializer_pkg.sv | 16 +
 rtl/deser_word_buffer.sv | 73 +++++++
 rtl/deserializer_n.sv | 99 +++++++++
 3 files changed

// File: rtl/deserializer_pkg.sv
// Shared types and default parameters for the serial-to-parallel deserializer.
// No logic, no latency.
// No flow control of its own.
package deserializer_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam bit DEFAULT_MSB_FIRST = 1'b1;

  // Bit-level receive state; STALL means both word slots are occupied
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECEIVING = 2'd1,
    STALL     = 2'd2
  } deser_state_t;

endpackage

// File: rtl/deser_word_buffer.sv
// Two-slot word buffer: output slot presented to the consumer plus one pending slot.
// Latency: a pushed word is visible on data_out the cycle after the push.
// Backpressure: full (busy_out) when both slots hold words; a push while full is lost.
module deser_word_buffer
  import deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock_100k,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             data_ready,
  output logic             busy_out,
  output logic             busy_next
);

  logic             out_vld;
  logic [WIDTH-1:0] out_dat;
  logic             pend_vld;
  logic [WIDTH-1:0] pend_dat;

  logic             out_vld_nxt;
  logic [WIDTH-1:0] out_dat_nxt;
  logic             pend_vld_nxt;
  logic [WIDTH-1:0] pend_dat_nxt;

  // Pop first (pending refills output), then place a new word in the first free slot
  always_comb begin
    out_vld_nxt  = out_vld;
    out_dat_nxt  = out_dat;
    pend_vld_nxt = pend_vld;
    pend_dat_nxt = pend_dat;
    if (pop && out_vld) begin
      out_vld_nxt  = pend_vld;
      out_dat_nxt  = pend_vld ? pend_dat : '0;
      pend_vld_nxt = 1'b0;
      pend_dat_nxt = '0;
    end
    if (push) begin
      if (!out_vld_nxt) begin
        out_vld_nxt = 1'b1;
        out_dat_nxt = push_data;
      end else if (!pend_vld_nxt) begin
        pend_vld_nxt = 1'b1;
        pend_dat_nxt = push_data;
      end
    end
  end

  // Slot registers
  always_ff @(posedge clock_100k or posedge reset) begin
    if (reset) begin
      out_vld  <= 1'b0;
      out_dat  <= '0;
      pend_vld <= 1'b0;
      pend_dat <= '0;
    end else begin
      out_vld  <= out_vld_nxt;
      out_dat  <= out_dat_nxt;
      pend_vld <= pend_vld_nxt;
      pend_dat <= pend_dat_nxt;
    end
  end

  assign data_out   = out_dat;
  assign data_ready = out_vld;
  assign busy_out   = out_vld & pend_vld;
  assign busy_next  = out_vld_nxt & pend_vld_nxt;

endmodule

// File: rtl/deserializer_n.sv
// Serial-to-parallel deserializer assembling WIDTH-bit words into a two-slot buffer.
// Latency: data_ready rises the cycle after the WIDTH-th bit is accepted.
// Backpressure: bits offered while both slots are full and not acked are dropped (sticky overflow_out).
module deserializer_n
  import deserializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = DEFAULT_MSB_FIRST
) (
  input  logic             clock_100k,
  input  logic             reset,
  input  logic             data_in,
  input  logic             write_in,
  input  logic             flush_in,
  input  logic             ack_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_ready,
  output logic             busy_out,
  output logic             overflow_out
);

  localparam int CW = $clog2(WIDTH + 1);

  deser_state_t     state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH-1:0] shift_nxt;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;
  logic             stalled;
  logic             bit_accept;
  logic             bit_drop;
  logic             word_done;
  logic             busy_next;

  // STALL tracks a full buffer; an ack in the same cycle frees a slot for the incoming bit
  assign stalled    = (state_q == STALL) && !ack_in;
  assign bit_accept = write_in && !stalled && !flush_in;
  assign bit_drop   = write_in && stalled;
  assign word_done  = bit_accept && (count_q == CW'(WIDTH - 1));
  assign shift_in   = MSB_FIRST ? {shift_q[WIDTH-2:0], data_in}
                                : {data_in, shift_q[WIDTH-1:1]};

  // Next counter/shift value; flush wins over a simultaneous bit
  always_comb begin
    count_nxt = count_q;
    shift_nxt = shift_q;
    if (flush_in) begin
      count_nxt = '0;
      shift_nxt = '0;
    end else if (bit_accept) begin
      if (word_done) begin
        count_nxt = '0;
        shift_nxt = '0;
      end else begin
        count_nxt = count_q + CW'(1);
        shift_nxt = shift_in;
      end
    end
  end

  // Receive FSM: state, bit counter, shift register and sticky overflow flag
  always_ff @(posedge clock_100k or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      shift_q      <= '0;
      overflow_out <= 1'b0;
    end else begin
      count_q <= count_nxt;
      shift_q <= shift_nxt;
      if (bit_drop) begin
        overflow_out <= 1'b1;
      end
      if (busy_next) begin
        state_q <= STALL;
      end else if (count_nxt != '0) begin
        state_q <= RECEIVING;
      end else begin
        state_q <= IDLE;
      end
    end
  end

  deser_word_buffer #(
    .WIDTH(WIDTH)
  ) u_word_buffer (
    .clock_100k (clock_100k),
    .reset      (reset),
    .push       (word_done),
    .push_data  (shift_in),
    .pop        (ack_in),
    .data_out   (data_out),
    .data_ready (data_ready),
    .busy_out   (busy_out),
    .busy_next  (busy_next)
  );

endmodule
